// File: rtl/hc595_receiver.sv
// hc595_receiver
//
// Receiving end of a 74HC595-style four-wire link (ser, srclk, rclk, oe).
// All four pins are asynchronous to clock and are oversampled through
// SYNC_STAGES-deep synchronizers. srclk rises shift ser into a WIDTH-bit
// shift chain, rclk rises copy the chain into an output latch, and active-low
// oe gates the latch onto q. sout is the cascade output for chaining devices.
//
// Ports
//   clock        system clock, all state on its rising edge
//   resetn       asynchronous active-low reset
//   ser          serial data pin
//   srclk        shift clock pin, rising edge shifts
//   rclk         latch clock pin, rising edge latches
//   oe           output enable pin, active low
//   q            latched data when enabled, else 0
//   latched      raw latch contents
//   out_enable   synchronized, inverted oe
//   sout         cascade output, top bit of the shift chain
//   latch_pulse  one-cycle strobe per accepted rclk rise
//   frame_error  set at latch time when the bit count was not WIDTH
//   bit_count    srclk rises since the last latch, saturating at WIDTH+1

module hc595_receiver #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CntW       = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ser,
  input  logic             srclk,
  input  logic             rclk,
  input  logic             oe,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] latched,
  output logic             out_enable,
  output logic             sout,
  output logic             latch_pulse,
  output logic             frame_error,
  output logic [CntW-1:0]  bit_count
);

  localparam int unsigned GuardCycles = SYNC_STAGES + 1;
  localparam int unsigned GuardW      = $clog2(GuardCycles + 1);
  localparam logic [CntW-1:0]   MaxCount  = CntW'(WIDTH + 1);
  localparam logic [CntW-1:0]   FullCount = CntW'(WIDTH);
  localparam logic [GuardW-1:0] GuardDone = GuardW'(GuardCycles);

  // ---------------------------------------------------------------------------
  // Input synchronizers. ser uses the same depth as srclk so the data bit seen
  // at the detected srclk edge is the one that was on the pin at the pin edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ser_sync_q;
  logic [SYNC_STAGES-1:0] srclk_sync_q;
  logic [SYNC_STAGES-1:0] rclk_sync_q;
  logic [SYNC_STAGES-1:0] oe_sync_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ser_sync_q   <= '0;
      srclk_sync_q <= '0;
      rclk_sync_q  <= '0;
      oe_sync_q    <= '1;  // outputs start disabled
    end else begin
      ser_sync_q   <= {ser_sync_q[SYNC_STAGES-2:0], ser};
      srclk_sync_q <= {srclk_sync_q[SYNC_STAGES-2:0], srclk};
      rclk_sync_q  <= {rclk_sync_q[SYNC_STAGES-2:0], rclk};
      oe_sync_q    <= {oe_sync_q[SYNC_STAGES-2:0], oe};
    end
  end

  logic ser_s;
  logic srclk_s;
  logic rclk_s;
  logic oe_s;

  assign ser_s   = ser_sync_q[SYNC_STAGES-1];
  assign srclk_s = srclk_sync_q[SYNC_STAGES-1];
  assign rclk_s  = rclk_sync_q[SYNC_STAGES-1];
  assign oe_s    = oe_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Startup guard. Synchronizers come out of reset at 0, so a pin already high
  // would look like a rising edge while the chain fills; edges are ignored
  // until the chain has flushed. prev keeps tracking so no edge is left over.
  // ---------------------------------------------------------------------------
  logic [GuardW-1:0] guard_cnt_q;
  logic [GuardW-1:0] guard_cnt_d;
  logic              guard_active;

  assign guard_active = (guard_cnt_q != GuardDone);

  always_comb begin
    guard_cnt_d = guard_cnt_q;
    if (guard_active) begin
      guard_cnt_d = guard_cnt_q + GuardW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      guard_cnt_q <= '0;
    end else begin
      guard_cnt_q <= guard_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic srclk_prev_q;
  logic rclk_prev_q;
  logic srclk_rise;
  logic rclk_rise;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      srclk_prev_q <= 1'b0;
      rclk_prev_q  <= 1'b0;
    end else begin
      srclk_prev_q <= srclk_s;
      rclk_prev_q  <= rclk_s;
    end
  end

  assign srclk_rise = srclk_s & ~srclk_prev_q & ~guard_active;
  assign rclk_rise  = rclk_s & ~rclk_prev_q & ~guard_active;

  // ---------------------------------------------------------------------------
  // Shift chain, output latch and frame accounting
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] latched_q;
  logic [WIDTH-1:0] latched_d;
  logic [CntW-1:0]  bit_count_q;
  logic [CntW-1:0]  bit_count_d;
  logic             latch_pulse_q;
  logic             latch_pulse_d;
  logic             frame_error_q;
  logic             frame_error_d;

  always_comb begin
    shift_d       = shift_q;
    latched_d     = latched_q;
    bit_count_d   = bit_count_q;
    latch_pulse_d = 1'b0;
    frame_error_d = frame_error_q;

    if (srclk_rise) begin
      shift_d = {shift_q[WIDTH-2:0], ser_s};
      if (bit_count_q != MaxCount) begin
        bit_count_d = bit_count_q + CntW'(1);
      end
    end

    // The latch copies the pre-shift chain, so with both clocks rising together
    // it runs one stage behind, as a real 595 with tied clocks does.
    if (rclk_rise) begin
      latched_d     = shift_q;
      latch_pulse_d = 1'b1;
      frame_error_d = (bit_count_q != FullCount);
      bit_count_d   = srclk_rise ? CntW'(1) : '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_q       <= '0;
      latched_q     <= '0;
      bit_count_q   <= '0;
      latch_pulse_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      latched_q     <= latched_d;
      bit_count_q   <= bit_count_d;
      latch_pulse_q <= latch_pulse_d;
      frame_error_q <= frame_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_enable  = ~oe_s;
  assign q           = out_enable ? latched_q : '0;
  assign latched     = latched_q;
  assign sout        = shift_q[WIDTH-1];
  assign latch_pulse = latch_pulse_q;
  assign frame_error = frame_error_q;
  assign bit_count   = bit_count_q;

endmodule

// File: tb/tb_hc595_receiver.sv
// Scoreboard bench for hc595_receiver. Stimulus pushes the expected latch
// result whenever it issues an rclk pulse; a monitor pops and compares on
// every latch_pulse. A second instance is chained on sout for the cascade case.

module tb_hc595_receiver;

  localparam int unsigned W = 16;

  logic          clock;
  logic          resetn;
  logic          ser;
  logic          srclk;
  logic          rclk;
  logic          oe;
  logic [W-1:0]  q;
  logic [W-1:0]  latched;
  logic          out_enable;
  logic          sout;
  logic          latch_pulse;
  logic          frame_error;
  logic [4:0]    bit_count;

  logic [W-1:0]  q_dn;
  logic [W-1:0]  latched_dn;
  logic          out_enable_dn;
  logic          sout_dn;
  logic          latch_pulse_dn;
  logic          frame_error_dn;
  logic [4:0]    bit_count_dn;

  hc595_receiver #(.WIDTH(W), .SYNC_STAGES(2)) u_dut (
    .clock      (clock),
    .resetn     (resetn),
    .ser        (ser),
    .srclk      (srclk),
    .rclk       (rclk),
    .oe         (oe),
    .q          (q),
    .latched    (latched),
    .out_enable (out_enable),
    .sout       (sout),
    .latch_pulse(latch_pulse),
    .frame_error(frame_error),
    .bit_count  (bit_count)
  );

  hc595_receiver #(.WIDTH(W), .SYNC_STAGES(2)) u_dn (
    .clock      (clock),
    .resetn     (resetn),
    .ser        (sout),
    .srclk      (srclk),
    .rclk       (rclk),
    .oe         (oe),
    .q          (q_dn),
    .latched    (latched_dn),
    .out_enable (out_enable_dn),
    .sout       (sout_dn),
    .latch_pulse(latch_pulse_dn),
    .frame_error(frame_error_dn),
    .bit_count  (bit_count_dn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] latched;
    logic         fe;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every latch strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (resetn && latch_pulse) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_latch_pulse: got latched=0x%0h, expected no pulse", latched);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_latched", 32'(latched), 32'(mon_e.latched));
        chk("sb_q", 32'(q), 32'(mon_e.q));
        chk("sb_frame_error", 32'(frame_error), 32'(mon_e.fe));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [W-1:0] l, input logic fe);
    exp_t e;
    e.latched = l;
    e.q       = l;  // oe is low whenever a latch is issued
    e.fe      = fe;
    sb_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    ser = b;
    tick(4);
    srclk = 1'b1;
    tick(4);
    srclk = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    tick(4);
  endtask

  task automatic latch();
    rclk = 1'b1;
    tick(4);
    rclk = 1'b0;
    tick(4);
  endtask

  // srclk and rclk rising together
  task automatic both_bit(input logic b);
    ser = b;
    tick(4);
    srclk = 1'b1;
    rclk  = 1'b1;
    tick(4);
    srclk = 1'b0;
    rclk  = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ser    = 1'b0;
    srclk  = 1'b0;
    rclk   = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(6);
  endtask

  logic [15:0] m_shift;
  logic [15:0] sim_val;

  initial begin
    resetn = 1'b0;
    ser    = 1'b0;
    srclk  = 1'b0;
    rclk   = 1'b0;
    oe     = 1'b0;
    tick(3);

    // Reset state
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_latched", 32'(latched), 32'h0);
    chk("rst_bit_count", 32'(bit_count), 32'h0);
    chk("rst_out_enable", 32'(out_enable), 32'h0);
    chk("rst_sout", 32'(sout), 32'h0);
    chk("rst_latch_pulse", 32'(latch_pulse), 32'h0);
    chk("rst_frame_error", 32'(frame_error), 32'h0);
    resetn = 1'b1;
    tick(6);
    chk("oe_after_reset", 32'(out_enable), 32'h1);

    // Basic frame
    send(32'hA5C3, 16);
    chk("basic_bit_count_pre", 32'(bit_count), 32'd16);
    push(16'hA5C3, 1'b0);
    latch();
    chk("basic_bit_count_post", 32'(bit_count), 32'd0);

    // Short frame from a cleared chain, then an over-long frame
    do_reset();
    send(32'hFF, 8);
    push(16'h00FF, 1'b1);
    latch();
    send(32'hABCDE, 20);
    chk("long_bit_count_sat", 32'(bit_count), 32'd17);
    push(16'hBCDE, 1'b1);
    latch();
    tick(10);
    chk("frame_error_held", 32'(frame_error), 32'h1);

    // Output enable
    send(32'h1234, 16);
    push(16'h1234, 1'b0);
    latch();
    oe = 1'b1;
    tick(3);
    chk("oe_off_q", 32'(q), 32'h0);
    chk("oe_off_latched", 32'(latched), 32'h1234);
    chk("oe_off_out_enable", 32'(out_enable), 32'h0);
    oe = 1'b0;
    tick(3);
    chk("oe_on_q", 32'(q), 32'h1234);

    // Simultaneous edges: the latch lags the chain by one edge
    do_reset();
    sim_val = 16'h8001;
    m_shift = 16'h0;
    for (int k = 0; k < 17; k++) begin
      logic b;
      b = (k < 16) ? sim_val[15-k] : 1'b0;
      push(m_shift, 1'b1);
      both_bit(b);
      m_shift = {m_shift[14:0], b};
    end
    tick(4);
    chk("sim_final_latched", 32'(latched), 32'h8001);

    // Reset mid-frame: chain now 0x0002, count 1; 7 ones make 0x017F, count 8
    send(32'h7F, 7);
    chk("mid_bit_count", 32'(bit_count), 32'd8);
    srclk  = 1'b1;
    ser    = 1'b0;
    resetn = 1'b0;
    tick(2);
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_latched", 32'(latched), 32'h0);
    chk("midrst_bit_count", 32'(bit_count), 32'h0);
    chk("midrst_out_enable", 32'(out_enable), 32'h0);
    chk("midrst_sout", 32'(sout), 32'h0);
    chk("midrst_frame_error", 32'(frame_error), 32'h0);
    resetn = 1'b1;
    tick(8);
    chk("guard_bit_count", 32'(bit_count), 32'h0);
    srclk = 1'b0;
    tick(4);
    send(32'h5A5A, 16);
    push(16'h5A5A, 1'b0);
    latch();

    // Cascade: 32 bits through both instances
    do_reset();
    send(32'hDEADBEEF, 32);
    push(16'hBEEF, 1'b1);
    latch();
    chk("cascade_downstream", 32'(latched_dn), 32'hDEAD);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick(1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
